// File: rtl/elevator_pkg.sv
// Shared types and constants for the LOOK-scheduled elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMoveUp = 2'd1,
    StMoveDn = 2'd2,
    StDoor   = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned CNT_W_DEFAULT = 8;

  function automatic state_e move_state(logic up);
    return (up == DIR_UP) ? StMoveUp : StMoveDn;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational scan: are there pending calls strictly ahead of / behind a floor
// for a given travel direction.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS = 8,
  parameter int unsigned POS_W  = 3
) (
  input  logic [FLOORS-1:0] pend,
  input  logic [POS_W-1:0]  pos,
  input  logic              dir_up,
  output logic              ahead,
  output logic              behind
);

  logic above, below;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pend[i] && (POS_W'(i) > pos)) above = 1'b1;
      if (pend[i] && (POS_W'(i) < pos)) below = 1'b1;
    end
    ahead  = (dir_up == DIR_UP) ? above : below;
    behind = (dir_up == DIR_UP) ? below : above;
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller with car/hall-up/hall-down calls, LOOK scheduling,
// multi-cycle travel and door hold/reopen.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS        = 8,
  parameter int unsigned POS_W         = 3,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned TRAVEL_CYCLES = 2,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  input  logic              door_hold,
  output logic [POS_W-1:0]  floor_pos,
  output logic              door_open,
  output logic              moving_up,
  output logic              moving_dn,
  output logic              dir_up,
  output logic              arrive,
  output logic [FLOORS-1:0] pend_car,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_dn
);

  localparam logic [FLOORS-1:0] UP_VALID    = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_VALID    = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0]  DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [POS_W-1:0]  TOP_FLOOR   = POS_W'(FLOORS - 1);

  state_e            state_q, state_d;
  logic [POS_W-1:0]  floor_q, floor_d, floor_step;
  logic              dir_q, dir_d;
  logic              arrive_q, arrive_d;
  logic [CNT_W-1:0]  door_cnt_q, door_cnt_d;
  logic [CNT_W-1:0]  travel_cnt_q, travel_cnt_d;
  logic [FLOORS-1:0] pend_car_q, pend_car_d;
  logic [FLOORS-1:0] pend_up_q, pend_up_d;
  logic [FLOORS-1:0] pend_dn_q, pend_dn_d;

  logic [FLOORS-1:0] up_in, dn_in, here, step_mask, pend_any;
  logic [FLOORS-1:0] clr_car, clr_up, clr_dn;
  logic              in_door, rereq;
  logic              at_f_car, at_f_up, at_f_dn, opp_f;
  logic              at_g_car, at_g_up, at_g_dn, same_g, opp_g;
  logic              ahead_f, behind_f, ahead_g, behind_g;

  assign up_in     = hall_up & UP_VALID;
  assign dn_in     = hall_dn & DN_VALID;
  assign here      = FLOORS'(1) << floor_q;
  assign in_door   = (state_q == StDoor);
  assign floor_step = (dir_q == DIR_UP) ? floor_q + POS_W'(1) : floor_q - POS_W'(1);
  assign step_mask = FLOORS'(1) << floor_step;

  // Door service clears the car call and the hall call matching the current direction.
  assign clr_car = in_door ? here : '0;
  assign clr_up  = (in_door && dir_q == DIR_UP) ? here : '0;
  assign clr_dn  = (in_door && dir_q == DIR_DN) ? here : '0;
  assign rereq   = |((car_req & clr_car) | (up_in & clr_up) | (dn_in & clr_dn));

  assign pend_car_d = (pend_car_q | car_req) & ~clr_car;
  assign pend_up_d  = (pend_up_q | up_in) & ~clr_up;
  assign pend_dn_d  = (pend_dn_q | dn_in) & ~clr_dn;
  assign pend_any   = pend_car_d | pend_up_d | pend_dn_d;

  assign at_f_car = |(pend_car_d & here);
  assign at_f_up  = |(pend_up_d & here);
  assign at_f_dn  = |(pend_dn_d & here);
  assign opp_f    = (dir_q == DIR_UP) ? at_f_dn : at_f_up;

  assign at_g_car = |(pend_car_d & step_mask);
  assign at_g_up  = |(pend_up_d & step_mask);
  assign at_g_dn  = |(pend_dn_d & step_mask);
  assign same_g   = at_g_car | ((dir_q == DIR_UP) ? at_g_up : at_g_dn);
  assign opp_g    = (dir_q == DIR_UP) ? at_g_dn : at_g_up;

  elevator_req_scan #(
    .FLOORS (FLOORS),
    .POS_W  (POS_W)
  ) u_scan_here (
    .pend   (pend_any),
    .pos    (floor_q),
    .dir_up (dir_q),
    .ahead  (ahead_f),
    .behind (behind_f)
  );

  elevator_req_scan #(
    .FLOORS (FLOORS),
    .POS_W  (POS_W)
  ) u_scan_step (
    .pend   (pend_any),
    .pos    (floor_step),
    .dir_up (dir_q),
    .ahead  (ahead_g),
    .behind (behind_g)
  );

  always_comb begin
    state_d      = state_q;
    floor_d      = floor_q;
    dir_d        = dir_q;
    arrive_d     = 1'b0;
    door_cnt_d   = '0;
    travel_cnt_d = '0;

    unique case (state_q)
      StIdle: begin
        if (at_f_car || at_f_up || at_f_dn) begin
          state_d = StDoor;
          if (at_f_up && !at_f_dn && !at_f_car) begin
            dir_d = DIR_UP;
          end else if (at_f_dn && !at_f_up && !at_f_car) begin
            dir_d = DIR_DN;
          end
        end else if (ahead_f) begin
          state_d = move_state(dir_q);
        end else if (behind_f) begin
          dir_d   = ~dir_q;
          state_d = move_state(~dir_q);
        end
      end

      StMoveUp, StMoveDn: begin
        if (travel_cnt_q == TRAVEL_LAST) begin
          floor_d  = floor_step;
          arrive_d = 1'b1;
          if (same_g) begin
            state_d = StDoor;
          end else if (opp_g && !ahead_g) begin
            state_d = StDoor;
            dir_d   = ~dir_q;
          end else if (floor_step == '0 || floor_step == TOP_FLOOR ||
                       !(ahead_g || behind_g)) begin
            // Safeguard against running past the shaft ends or wandering with no calls.
            state_d = StIdle;
          end
        end else begin
          travel_cnt_d = travel_cnt_q + CNT_W'(1);
        end
      end

      StDoor: begin
        if (rereq || door_hold) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          if (ahead_f) begin
            state_d = move_state(dir_q);
          end else if (opp_f) begin
            dir_d = ~dir_q;  // reopen for the opposite hall call, counter restarts
          end else if (behind_f) begin
            dir_d   = ~dir_q;
            state_d = move_state(~dir_q);
          end else begin
            state_d = StIdle;
          end
        end else begin
          door_cnt_d = door_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      floor_q      <= '0;
      dir_q        <= DIR_UP;
      arrive_q     <= 1'b0;
      door_cnt_q   <= '0;
      travel_cnt_q <= '0;
      pend_car_q   <= '0;
      pend_up_q    <= '0;
      pend_dn_q    <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      arrive_q     <= arrive_d;
      door_cnt_q   <= door_cnt_d;
      travel_cnt_q <= travel_cnt_d;
      pend_car_q   <= pend_car_d;
      pend_up_q    <= pend_up_d;
      pend_dn_q    <= pend_dn_d;
    end
  end

  assign floor_pos = floor_q;
  assign door_open = (state_q == StDoor);
  assign moving_up = (state_q == StMoveUp);
  assign moving_dn = (state_q == StMoveDn);
  assign dir_up    = dir_q;
  assign arrive    = arrive_q;
  assign pend_car  = pend_car_q;
  assign pend_up   = pend_up_q;
  assign pend_dn   = pend_dn_q;

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
Next-generation single-car elevator controller. It adds car calls and separate hall-up and hall-down calls, multi-cycle inter-floor travel, and door-hold/reopen. It uses LOOK scheduling: the car serves calls in its travel direction and reverses only when nothing lies ahead. It sits beside the legacy bitmask controller and drives the same floor/door/motion indicators, plus pending-call masks for panel lamps.

Parameters:
FLOORS, 8, number of floors, indices 0..FLOORS-1 (FLOORS >= 2)
POS_W, 3, floor index width; must satisfy 2**POS_W >= FLOORS
DOOR_CYCLES, 4, cycles the door stays open per service (>= 1)
TRAVEL_CYCLES, 2, cycles to move one floor (>= 1)
CNT_W, 8, width of the door and travel counters; must hold max(DOOR_CYCLES, TRAVEL_CYCLES)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
car_req  in  FLOORS  car-panel call bitmask, level or pulse
hall_up  in  FLOORS  hall up-call bitmask (bit FLOORS-1 ignored)
hall_dn  in  FLOORS  hall down-call bitmask (bit 0 ignored)
door_hold  in  1  while high in DOOR, door counter held at 0
floor_pos  out  POS_W  current floor index
door_open  out  1  high in DOOR state
moving_up  out  1  high in MOVE_UP
moving_dn  out  1  high in MOVE_DN
dir_up  out  1  current scan direction (1 = up)
arrive  out  1  one-cycle pulse on the cycle floor_pos changes
pend_car  out  FLOORS  latched car calls
pend_up  out  FLOORS  latched hall-up calls
pend_dn  out  FLOORS  latched hall-down calls

Behaviour:
- Reset, synchronous: state IDLE, floor_pos 0, all pend_* 0, dir_up 1, counters 0, door_open, moving_up, moving_dn and arrive 0. Inputs in the reset cycle are ignored. Reset mid-travel or mid-door aborts immediately; the car reappears at floor 0 on the next cycle.
- Pending next-state: pend_d = pend_q | inputs, minus this cycle's clears. A clear wins over a same-cycle set. All decisions use pend_d, so a request in cycle N can change state at edge N+1.
- Definitions: f = floor_pos; any = car|up|dn pending; ahead = any bit strictly beyond f in dir_up direction; behind = any bit strictly on the other side.
- States: IDLE, MOVE_UP, MOVE_DN, DOOR. Outputs are Moore (decoded from registered state).
- IDLE:
  - any call at f -> DOOR; dir_up set to 1 if only up[f] is set, 0 if only dn[f], otherwise unchanged.
  - else if ahead -> move in dir_up.
  - else if behind -> flip dir_up and move.
  - else stay IDLE.
- MOVE_x:
  - Travel counter counts 0..TRAVEL_CYCLES-1. On the last count, floor_pos steps by ±1, arrive pulses, and the counter resets.
  - At the new floor g, stop (-> DOOR) if car[g], or the hall bit of the current direction at g, or (no calls beyond g in the current direction and the opposite hall bit at g is set). In that last case dir_up flips on entry.
  - Otherwise continue. Reaching floor 0 or FLOORS-1 without a stop -> IDLE (safeguard only).
- DOOR:
  - Every cycle, clear car[f] and the hall bit at f matching dir_up.
  - If a cleared bit is newly re-requested that cycle, or door_hold is high, the door counter resets to 0 (door stays open).
  - Otherwise the counter increments. At DOOR_CYCLES-1 the door closes, choosing in priority order:
    - ahead -> move in dir_up.
    - else opposite hall bit at f pending -> flip dir_up, stay in DOOR, counter 0 (reopen in the new direction).
    - else behind -> flip dir_up and move.
    - else IDLE.
- Moves are always exactly one floor per TRAVEL_CYCLES. floor_pos never wraps.
- hall_up[FLOORS-1] and hall_dn[0] are forced to 0 in pend_d.

Decomposition:
- Package elevator_pkg holds: the state encoding (IDLE/MOVE_UP/MOVE_DN/DOOR), DIR_UP/DIR_DN constants, and the default counter width.
- One combinational sub-module, elevator_req_scan: inputs are a pending mask, floor index and direction; outputs are ahead/behind flags. It is instantiated twice, once for the current floor and once for the arrival floor.

Test Plan:
1. FLOORS=8, TRAVEL=2, DOOR=4. After reset, pulse car_req[0] -> door_open=1 for 4 cycles starting the next cycle; pend_car[0]=0; then IDLE with all outputs 0.
2. At floor 0 IDLE, pulse car_req[3] -> moving_up=1; floor_pos reads 1, 2, 3 at 2-cycle intervals with arrive pulses; door_open for 4 cycles; return to IDLE.
3. Moving up from floor 2 toward car_req[5], press hall_dn[3] -> no stop at 3; serve 5; dir_up->0; travel down; stop at 3; pend_dn[3] clears during DOOR.
4. IDLE at floor 4, dir_up=1, press hall_up[4] and hall_dn[4] together -> door_open stays high 8 consecutive cycles; dir_up flips at cycle 4; both pend bits end at 0.
5. In DOOR, hold door_hold high for 5 cycles starting at counter 2 -> door closes exactly 4 cycles after door_hold falls.
6. Assert reset for 1 cycle during MOVE_UP at floor 3 -> next cycle floor_pos=0, pend_*=0, IDLE, dir_up=1.
